// File: rtl/key_extract.sv
// key_extract: two-stage match-key builder feeding the stage lookup engine.
// Stage 1 latches the PHV and the VID-indexed config entry; stage 2 muxes the
// selected containers into the 197-bit key and registers it with the PHV.
module key_extract #(
    parameter int STAGE   = 0,
    parameter int PHV_LEN = 1124,
    parameter int KEY_LEN = 197,
    parameter int CFG_LEN = 23
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PHV_LEN-1:0]  phv_in,
    input  logic                phv_valid_in,
    input  logic                key_cfg_en,
    input  logic [3:0]          key_cfg_stage,
    input  logic [3:0]          key_cfg_addr,
    input  logic [CFG_LEN-1:0]  key_cfg_data,
    output logic [KEY_LEN-1:0]  key_out,
    output logic                key_valid_out,
    output logic [PHV_LEN-1:0]  phv_out
);

    // Container base offsets inside the PHV
    localparam int C48_BASE = 740;
    localparam int C32_BASE = 484;
    localparam int C16_BASE = 356;
    localparam int COND_LSB = 256;
    localparam int VID_LSB  = 252;

    localparam logic [3:0] STAGE_ID = 4'(STAGE);

    // Pick 48b container number sel out of a PHV
    function automatic logic [47:0] c48_f(input logic [PHV_LEN-1:0] phv, input logic [2:0] sel);
        return phv[C48_BASE + 48 * int'(sel) +: 48];
    endfunction

    // Pick 32b container number sel out of a PHV
    function automatic logic [31:0] c32_f(input logic [PHV_LEN-1:0] phv, input logic [2:0] sel);
        return phv[C32_BASE + 32 * int'(sel) +: 32];
    endfunction

    // Pick 16b container number sel out of a PHV
    function automatic logic [15:0] c16_f(input logic [PHV_LEN-1:0] phv, input logic [2:0] sel);
        return phv[C16_BASE + 16 * int'(sel) +: 16];
    endfunction

    logic [CFG_LEN-1:0] cfg_table_r [16];
    logic               cfg_wr_s;
    logic [3:0]         vid_s;

    logic               s1_valid_r;
    logic [PHV_LEN-1:0] s1_phv_r;
    logic [CFG_LEN-1:0] s1_cfg_r;
    logic [KEY_LEN-1:0] key_s;

    assign cfg_wr_s = key_cfg_en && (key_cfg_stage == STAGE_ID);
    assign vid_s    = phv_in[VID_LSB +: 4];

    // Configuration table: cleared on reset, written only for this stage id
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                cfg_table_r[i] <= {CFG_LEN{1'b0}};
            end
        end else if (cfg_wr_s) begin
            cfg_table_r[key_cfg_addr] <= key_cfg_data;
        end
    end

    // Stage 1: capture PHV and its config entry (old entry wins on a same-cycle write)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_phv_r   <= {PHV_LEN{1'b0}};
            s1_cfg_r   <= {CFG_LEN{1'b0}};
        end else begin
            s1_valid_r <= phv_valid_in;
            if (phv_valid_in) begin
                s1_phv_r <= phv_in;
                s1_cfg_r <= cfg_table_r[vid_s];
            end
        end
    end

    // Key mux: selector fields MSB first, then the condition mask
    always_comb begin
        key_s = {c48_f(s1_phv_r, s1_cfg_r[22:20]),
                 c48_f(s1_phv_r, s1_cfg_r[19:17]),
                 c32_f(s1_phv_r, s1_cfg_r[16:14]),
                 c32_f(s1_phv_r, s1_cfg_r[13:11]),
                 c16_f(s1_phv_r, s1_cfg_r[10:8]),
                 c16_f(s1_phv_r, s1_cfg_r[7:5]),
                 s1_phv_r[COND_LSB +: 5] & s1_cfg_r[4:0]};
    end

    // Stage 2: register key/PHV on a valid stage-1 entry, otherwise hold them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_valid_out <= 1'b0;
            key_out       <= {KEY_LEN{1'b0}};
            phv_out       <= {PHV_LEN{1'b0}};
        end else begin
            key_valid_out <= s1_valid_r;
            if (s1_valid_r) begin
                key_out <= key_s;
                phv_out <= s1_phv_r;
            end
        end
    end

endmodule

// File: tb/tb_key_extract.sv
// Directed, table-driven bench for key_extract.
module tb_key_extract;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1123:0]  phv_in;
    logic           phv_valid_in;
    logic           key_cfg_en;
    logic [3:0]     key_cfg_stage;
    logic [3:0]     key_cfg_addr;
    logic [22:0]    key_cfg_data;
    logic [196:0]   key_out;
    logic           key_valid_out;
    logic [1123:0]  phv_out;

    int n_checks = 0;
    int n_fail   = 0;

    key_extract #(.STAGE(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .phv_in        (phv_in),
        .phv_valid_in  (phv_valid_in),
        .key_cfg_en    (key_cfg_en),
        .key_cfg_stage (key_cfg_stage),
        .key_cfg_addr  (key_cfg_addr),
        .key_cfg_data  (key_cfg_data),
        .key_out       (key_out),
        .key_valid_out (key_valid_out),
        .phv_out       (phv_out)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [3:0]  wr_stage;
        logic [3:0]  wr_addr;
        logic [22:0] wr_data;
        logic [3:0]  vid;
        logic [4:0]  cond;
        logic [7:0]  seed;
        logic [2:0]  e48a, e48b, e32a, e32b, e16a, e16b;
        logic [4:0]  emask;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [47:0] pat48(input logic [7:0] seed, input logic [2:0] i);
        return {8'h48, seed, 29'd0, i};
    endfunction
    function automatic logic [31:0] pat32(input logic [7:0] seed, input logic [2:0] i);
        return {8'h32, seed, 13'd0, i};
    endfunction
    function automatic logic [15:0] pat16(input logic [7:0] seed, input logic [2:0] i);
        return {4'h6, seed[3:0], 5'd0, i};
    endfunction

    function automatic logic [22:0] pack_cfg(input logic [2:0] a, b, c, d, e, f, input logic [4:0] m);
        return {a, b, c, d, e, f, m};
    endfunction

    // PHV with unique container patterns and filler in the unused fields
    function automatic logic [1123:0] mk_phv(input logic [7:0] seed, input logic [3:0] vid, input logic [4:0] cond);
        logic [1123:0] p;
        logic [255:0]  lo;
        logic [127:0]  hi;
        lo = {32{seed ^ 8'h5A}};
        hi = {16{~seed}};
        p = '0;
        p[251:0]   = lo[251:0];
        p[255:252] = vid;
        p[260:256] = cond;
        p[355:261] = hi[94:0];
        for (int i = 0; i < 8; i++) begin
            p[356 + 16*i +: 16] = pat16(seed, 3'(i));
            p[484 + 32*i +: 32] = pat32(seed, 3'(i));
            p[740 + 48*i +: 48] = pat48(seed, 3'(i));
        end
        return p;
    endfunction

    function automatic logic [196:0] exp_key(input logic [7:0] seed, input logic [4:0] cond,
                                             input logic [2:0] a, b, c, d, e, f, input logic [4:0] m);
        return {pat48(seed, a), pat48(seed, b), pat32(seed, c), pat32(seed, d),
                pat16(seed, e), pat16(seed, f), cond & m};
    endfunction

    function automatic logic [196:0] exp_from_cfg(input logic [7:0] seed, input logic [4:0] cond, input logic [22:0] cfg);
        return exp_key(seed, cond, cfg[22:20], cfg[19:17], cfg[16:14], cfg[13:11], cfg[10:8], cfg[7:5], cfg[4:0]);
    endfunction

    task automatic chk_bit(input string nm, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic chk_key(input string nm, input logic [196:0] got, input logic [196:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: key got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_phv(input string nm, input logic [1123:0] got, input logic [1123:0] exp);
        int base;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            base = 0;
            for (int b = 1123; b >= 0; b--) begin
                if (got[b] !== exp[b]) base = b;
            end
            if (base > 1060) base = 1060;
            $display("FAIL %s: phv[%0d+:64] got %h expected %h", nm, base, got[base +: 64], exp[base +: 64]);
        end
    endtask

    task automatic cfg_write(input logic [3:0] stage, input logic [3:0] addr, input logic [22:0] data);
        @(negedge clk);
        key_cfg_en    = 1'b1;
        key_cfg_stage = stage;
        key_cfg_addr  = addr;
        key_cfg_data  = data;
        @(negedge clk);
        key_cfg_en    = 1'b0;
    endtask

    // Single PHV (optionally with a same-cycle config write) and full output check
    task automatic send_check(input string nm, input logic [1123:0] phv, input logic [196:0] ek,
                              input logic do_wr, input logic [3:0] ws, input logic [3:0] wa,
                              input logic [22:0] wd);
        @(negedge clk);
        phv_in        = phv;
        phv_valid_in  = 1'b1;
        key_cfg_en    = do_wr;
        key_cfg_stage = ws;
        key_cfg_addr  = wa;
        key_cfg_data  = wd;
        @(negedge clk);
        phv_valid_in  = 1'b0;
        phv_in        = '0;
        key_cfg_en    = 1'b0;
        chk_bit({nm, " not early"}, key_valid_out, 1'b0);
        @(negedge clk);
        chk_bit({nm, " valid"}, key_valid_out, 1'b1);
        chk_key({nm, " key"}, key_out, ek);
        chk_phv({nm, " phv"}, phv_out, phv);
        @(negedge clk);
        chk_bit({nm, " pulse end"}, key_valid_out, 1'b0);
        chk_key({nm, " key hold"}, key_out, ek);
        @(negedge clk);
    endtask

    logic [1123:0] p;
    logic [22:0]   bb_cfg [4];
    logic [7:0]    bb_seed [4];
    logic [4:0]    bb_cond [4];

    initial begin
        vecs[0] = '{1'b1, 4'd0,  4'd3,  pack_cfg(3'd7, 3'd1, 3'd2, 3'd5, 3'd4, 3'd0, 5'b10101),
                    4'd3,  5'b01110, 8'h11, 3'd7, 3'd1, 3'd2, 3'd5, 3'd4, 3'd0, 5'b10101};
        vecs[1] = '{1'b1, 4'd2,  4'd3,  pack_cfg(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 5'b11111),
                    4'd3,  5'b01110, 8'h11, 3'd7, 3'd1, 3'd2, 3'd5, 3'd4, 3'd0, 5'b10101};
        vecs[2] = '{1'b1, 4'd0,  4'd15, pack_cfg(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 5'b11111),
                    4'd15, 5'b10011, 8'h33, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 5'b11111};
        vecs[3] = '{1'b0, 4'd0,  4'd0,  23'd0,
                    4'd9,  5'b11111, 8'h44, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 5'b00000};
        vecs[4] = '{1'b1, 4'd0,  4'd9,  pack_cfg(3'd6, 3'd6, 3'd7, 3'd7, 3'd3, 3'd3, 5'b01010),
                    4'd9,  5'b11111, 8'h55, 3'd6, 3'd6, 3'd7, 3'd7, 3'd3, 3'd3, 5'b01010};
        vecs[5] = '{1'b1, 4'd15, 4'd9,  pack_cfg(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 5'b00000),
                    4'd9,  5'b10101, 8'h66, 3'd6, 3'd6, 3'd7, 3'd7, 3'd3, 3'd3, 5'b01010};

        bb_cfg[0] = pack_cfg(3'd1, 3'd0, 3'd3, 3'd2, 3'd5, 3'd4, 5'b00001);
        bb_cfg[1] = pack_cfg(3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 5'b00011);
        bb_cfg[2] = pack_cfg(3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 5'b11000);
        bb_cfg[3] = pack_cfg(3'd0, 3'd7, 3'd0, 3'd7, 3'd0, 3'd7, 5'b11111);
        bb_seed[0] = 8'hB0; bb_seed[1] = 8'hB1; bb_seed[2] = 8'hB2; bb_seed[3] = 8'hB3;
        bb_cond[0] = 5'h1F; bb_cond[1] = 5'h15; bb_cond[2] = 5'h0A; bb_cond[3] = 5'h13;

        rst_n         = 1'b0;
        phv_in        = '0;
        phv_valid_in  = 1'b0;
        key_cfg_en    = 1'b0;
        key_cfg_stage = 4'd0;
        key_cfg_addr  = 4'd0;
        key_cfg_data  = 23'd0;

        // Reset defaults
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_bit("reset valid", key_valid_out, 1'b0);
        chk_key("reset key", key_out, 197'd0);
        chk_phv("reset phv", phv_out, 1124'd0);
        rst_n = 1'b1;

        p = '0;
        p[740 +: 48] = 48'hAABBCCDDEEFF;
        p[484 +: 32] = 32'h11223344;
        p[356 +: 16] = 16'h5566;
        p[260:256]   = 5'h1F;
        send_check("default cfg", p,
                   {48'hAABBCCDDEEFF, 48'hAABBCCDDEEFF, 32'h11223344, 32'h11223344,
                    16'h5566, 16'h5566, 5'h00},
                   1'b0, 4'd0, 4'd0, 23'd0);

        // Table-driven config/select vectors
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].do_wr) cfg_write(vecs[v].wr_stage, vecs[v].wr_addr, vecs[v].wr_data);
            send_check($sformatf("vec%0d", v), mk_phv(vecs[v].seed, vecs[v].vid, vecs[v].cond),
                       exp_key(vecs[v].seed, vecs[v].cond, vecs[v].e48a, vecs[v].e48b, vecs[v].e32a,
                               vecs[v].e32b, vecs[v].e16a, vecs[v].e16b, vecs[v].emask),
                       1'b0, 4'd0, 4'd0, 23'd0);
        end

        // Write/read collision: same-cycle write to entry 5 is not seen by this PHV
        send_check("collide old", mk_phv(8'h77, 4'd5, 5'h1F),
                   exp_key(8'h77, 5'h1F, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 5'b00000),
                   1'b1, 4'd0, 4'd5, pack_cfg(3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 5'b11111));
        send_check("collide new", mk_phv(8'h88, 4'd5, 5'h0F),
                   exp_key(8'h88, 5'h0F, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 5'b11111),
                   1'b0, 4'd0, 4'd0, 23'd0);

        // Back-to-back PHVs with VIDs 0..3
        for (int e = 0; e < 4; e++) cfg_write(4'd0, 4'(e), bb_cfg[e]);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                chk_bit($sformatf("b2b%0d valid", k-2), key_valid_out, 1'b1);
                chk_key($sformatf("b2b%0d key", k-2), key_out,
                        exp_from_cfg(bb_seed[k-2], bb_cond[k-2], bb_cfg[k-2]));
                chk_phv($sformatf("b2b%0d phv", k-2), phv_out,
                        mk_phv(bb_seed[k-2], 4'(k-2), bb_cond[k-2]));
            end else begin
                chk_bit($sformatf("b2b lead%0d", k), key_valid_out, 1'b0);
            end
            if (k < 4) begin
                phv_in       = mk_phv(bb_seed[k], 4'(k), bb_cond[k]);
                phv_valid_in = 1'b1;
            end else begin
                phv_in       = '0;
                phv_valid_in = 1'b0;
            end
        end
        @(negedge clk);
        chk_bit("b2b tail", key_valid_out, 1'b0);
        chk_key("b2b hold", key_out, exp_from_cfg(bb_seed[3], bb_cond[3], bb_cfg[3]));
        repeat (3) @(negedge clk);

        // Reset mid-flight drops the in-flight PHV
        phv_in       = mk_phv(8'hAB, 4'd2, 5'h1F);
        phv_valid_in = 1'b1;
        @(negedge clk);
        phv_valid_in = 1'b0;
        phv_in       = '0;
        rst_n        = 1'b0;
        chk_bit("midrst s1", key_valid_out, 1'b0);
        @(negedge clk);
        chk_bit("midrst valid", key_valid_out, 1'b0);
        chk_key("midrst key", key_out, 197'd0);
        chk_phv("midrst phv", phv_out, 1124'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_bit("midrst after1", key_valid_out, 1'b0);
        @(negedge clk);
        chk_bit("midrst after2", key_valid_out, 1'b0);

        // Table was cleared by the reset: entry 2 back to defaults
        send_check("post-reset table", mk_phv(8'hCD, 4'd2, 5'h1F),
                   exp_key(8'hCD, 5'h1F, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 5'b00000),
                   1'b0, 4'd0, 4'd0, 23'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
